mem_wb_stage: RTL and testbench

- MEM/WB pipeline register and write-back/forwarding stage, directly downstream of the memory-write unit.
- Captures the load path (partial-load result) and the ALU/memory mux result, then selects the write-back value.
- Drives the register-file write port.
- Keeps a two-deep history of retired writes and supplies bypass selects/values to the execute stage.

---
 rtl/mem_wb_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register and write-back / forwarding stage.
//               Captures the memory-stage result, drives the register-file
//               write port and keeps a two-deep history (WB entry + retired
//               entry) used to generate execute-stage bypass selects/values.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: MEM_WB_RETIRE_COUNT_EN
//   defined   -> RetireCount counts retired instructions (wraps at 2^32)
//   undefined -> RetireCount is tied to 0, no counter logic is built
// ----------------------------------------------------------------------------
// Ports
//   Clk          in   1       system clock, rising edge
//   Rst          in   1       synchronous active-low reset
//   LoadData     in   DATA_W  partial-load result from memory stage
//   ResultData   in   DATA_W  ALU/memory mux result from memory stage
//   selLoad      in   1       1 = write back LoadData, 0 = ResultData
//   RegWrite_in  in   1       instruction writes a register
//   WriteReg_in  in   REG_AW  destination register
//   Valid_in     in   1       memory-stage slot holds a real instruction
//   Stall        in   1       hold stage contents
//   Flush        in   1       kill incoming instruction
//   RsAddr       in   REG_AW  execute-stage source A
//   RtAddr       in   REG_AW  execute-stage source B
//   WriteData    out  DATA_W  register-file write data
//   WriteReg     out  REG_AW  register-file write address
//   RegWrite     out  1       register-file write enable
//   ForwardA     out  2       00 none, 01 WB entry, 10 retired entry
//   ForwardB     out  2       same encoding for RtAddr
//   FwdDataA     out  DATA_W  bypass value for A (0 when ForwardA = 00)
//   FwdDataB     out  DATA_W  bypass value for B (0 when ForwardB = 00)
//   RetireCount  out  32      retired-instruction count
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] LoadData,
    input  logic [DATA_W-1:0] ResultData,
    input  logic              selLoad,
    input  logic              RegWrite_in,
    input  logic [REG_AW-1:0] WriteReg_in,
    input  logic              Valid_in,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [REG_AW-1:0] RsAddr,
    input  logic [REG_AW-1:0] RtAddr,
    output logic [DATA_W-1:0] WriteData,
    output logic [REG_AW-1:0] WriteReg,
    output logic              RegWrite,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic [DATA_W-1:0] FwdDataA,
    output logic [DATA_W-1:0] FwdDataB,
    output logic [31:0]       RetireCount
);

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_RET  = 2'b10;

    // ------------------------------------------------------------------
    // Stored entries
    // ------------------------------------------------------------------
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              ret_valid;
    logic [REG_AW-1:0] ret_addr;
    logic [DATA_W-1:0] ret_data;

    logic [DATA_W-1:0] capture_data;

    assign capture_data = selLoad ? LoadData : ResultData;

    // WB entry: flush kills only the valid bit; data/address are don't-care
    // once the entry is invalid, so they simply hold.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (Flush) begin
            wb_valid <= 1'b0;
        end else if (!Stall) begin
            wb_valid <= Valid_in & RegWrite_in;
            wb_addr  <= WriteReg_in;
            wb_data  <= capture_data;
        end
    end

    // Retired entry advances only when the pipeline moves, so a stalled
    // write is never duplicated into history. Flush leaves it alone because
    // the instruction it holds has already committed.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ret_valid <= 1'b0;
            ret_addr  <= '0;
            ret_data  <= '0;
        end else if (!Stall) begin
            ret_valid <= wb_valid;
            ret_addr  <= wb_addr;
            ret_data  <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Register-file write port
    // ------------------------------------------------------------------
    assign RegWrite  = wb_valid & (wb_addr != '0);
    assign WriteData = wb_data;
    assign WriteReg  = wb_addr;

    // ------------------------------------------------------------------
    // Forwarding: newer (WB) entry wins over the retired entry; source $0
    // never forwards since it is hardwired to zero.
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_select(
        input logic [REG_AW-1:0] src,
        input logic              wv,
        input logic [REG_AW-1:0] wa,
        input logic              rv,
        input logic [REG_AW-1:0] ra
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (src == '0) begin
            sel = FWD_NONE;
        end else if (wv && (wa != '0) && (wa == src)) begin
            sel = FWD_WB;
        end else if (rv && (ra == src)) begin
            sel = FWD_RET;
        end
        return sel;
    endfunction

    always_comb begin
        ForwardA = fwd_select(RsAddr, wb_valid, wb_addr, ret_valid, ret_addr);
        ForwardB = fwd_select(RtAddr, wb_valid, wb_addr, ret_valid, ret_addr);
    end

    always_comb begin
        FwdDataA = '0;
        FwdDataB = '0;
        case (ForwardA)
            FWD_WB:  FwdDataA = wb_data;
            FWD_RET: FwdDataA = ret_data;
            default: FwdDataA = '0;
        endcase
        case (ForwardB)
            FWD_WB:  FwdDataB = wb_data;
            FWD_RET: FwdDataB = ret_data;
            default: FwdDataB = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------
`ifdef MEM_WB_RETIRE_COUNT_EN
    // Separate valid bit: non-writing instructions still retire, so this
    // tracks Valid_in alone rather than the write-enable qualified valid.
    logic        wb_retire;
    logic [31:0] retire_cnt;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wb_retire <= 1'b0;
        end else if (Flush) begin
            wb_retire <= 1'b0;
        end else if (!Stall) begin
            wb_retire <= Valid_in;
        end
    end

    // Natural 32-bit wrap from 0xFFFFFFFF to 0.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            retire_cnt <= '0;
        end else if (!Stall && wb_retire) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign RetireCount = retire_cnt;
`else
    assign RetireCount = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. Table of directed
//               vectors with hand-computed expectations, plus hand-written
//               sequences for stall, flush, reset-priority and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        Clk;
    logic        Rst;
    logic [31:0] LoadData;
    logic [31:0] ResultData;
    logic        selLoad;
    logic        RegWrite_in;
    logic [4:0]  WriteReg_in;
    logic        Valid_in;
    logic        Stall;
    logic        Flush;
    logic [4:0]  RsAddr;
    logic [4:0]  RtAddr;
    logic [31:0] WriteData;
    logic [4:0]  WriteReg;
    logic        RegWrite;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic [31:0] FwdDataA;
    logic [31:0] FwdDataB;
    logic [31:0] RetireCount;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .Clk(Clk), .Rst(Rst),
        .LoadData(LoadData), .ResultData(ResultData), .selLoad(selLoad),
        .RegWrite_in(RegWrite_in), .WriteReg_in(WriteReg_in),
        .Valid_in(Valid_in), .Stall(Stall), .Flush(Flush),
        .RsAddr(RsAddr), .RtAddr(RtAddr),
        .WriteData(WriteData), .WriteReg(WriteReg), .RegWrite(RegWrite),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .FwdDataA(FwdDataA), .FwdDataB(FwdDataB),
        .RetireCount(RetireCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        sel;
        logic [31:0] load;
        logic [31:0] res;
        logic        rw;
        logic [4:0]  wr;
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] e_wdata;
        logic [4:0]  e_wreg;
        logic        e_rw;
        logic [1:0]  e_fa;
        logic [1:0]  e_fb;
        logic [31:0] e_fda;
        logic [31:0] e_fdb;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [31:0] load, input logic [31:0] res,
                         input logic rw, input logic [4:0] wr, input logic v,
                         input logic [4:0] rs, input logic [4:0] rt);
        selLoad = sel; LoadData = load; ResultData = res;
        RegWrite_in = rw; WriteReg_in = wr; Valid_in = v;
        RsAddr = rs; RtAddr = rt;
    endtask

    task automatic chk_port(input string tag, input logic [31:0] wd, input logic [4:0] wreg,
                            input logic rw, input logic [1:0] fa, input logic [1:0] fb,
                            input logic [31:0] fda, input logic [31:0] fdb);
        chk({tag, ".WriteData"}, WriteData, wd);
        chk({tag, ".WriteReg"},  {27'd0, WriteReg}, {27'd0, wreg});
        chk({tag, ".RegWrite"},  {31'd0, RegWrite}, {31'd0, rw});
        chk({tag, ".ForwardA"},  {30'd0, ForwardA}, {30'd0, fa});
        chk({tag, ".ForwardB"},  {30'd0, ForwardB}, {30'd0, fb});
        chk({tag, ".FwdDataA"},  FwdDataA, fda);
        chk({tag, ".FwdDataB"},  FwdDataB, fdb);
    endtask

    // Watchdog: the sequence is fixed-length, this only guards against a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cnt_before;

        //                sel load         res          rw wr v  rs rt   wdata        wreg rw fa     fb     fda          fdb
        vecs[0] = '{1'b1, 32'hFFFFFF80, 32'h1234, 1'b1, 5'd8, 1'b1, 5'd8, 5'd0,
                    32'hFFFFFF80, 5'd8, 1'b1, 2'b01, 2'b00, 32'hFFFFFF80, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 32'h5, 1'b1, 5'd0, 1'b1, 5'd0, 5'd8,
                    32'h5, 5'd0, 1'b0, 2'b00, 2'b10, 32'h0, 32'hFFFFFF80};
        vecs[2] = '{1'b0, 32'h0, 32'hA, 1'b1, 5'd3, 1'b1, 5'd3, 5'd0,
                    32'hA, 5'd3, 1'b1, 2'b01, 2'b00, 32'hA, 32'h0};
        vecs[3] = '{1'b0, 32'h0, 32'hB, 1'b1, 5'd3, 1'b1, 5'd3, 5'd3,
                    32'hB, 5'd3, 1'b1, 2'b01, 2'b01, 32'hB, 32'hB};
        // non-writing valid instruction: r3 now only in retired entry
        vecs[4] = '{1'b0, 32'h0, 32'h77, 1'b0, 5'd5, 1'b1, 5'd3, 5'd5,
                    32'h77, 5'd5, 1'b0, 2'b10, 2'b00, 32'hB, 32'h0};
        // RegWrite_in with Valid_in = 0 must never forward
        vecs[5] = '{1'b0, 32'h0, 32'h99, 1'b1, 5'd9, 1'b0, 5'd9, 5'd5,
                    32'h99, 5'd9, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0};
        vecs[6] = '{1'b0, 32'h0, 32'hC1, 1'b1, 5'd9, 1'b1, 5'd9, 5'd1,
                    32'hC1, 5'd9, 1'b1, 2'b01, 2'b00, 32'hC1, 32'h0};

        // ---------------- reset then idle ----------------
        Rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        tick(); tick();
        Rst = 1'b1;
        tick();
        chk_port("reset", 32'h0, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk("reset.RetireCount", RetireCount, 32'h0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].sel, vecs[i].load, vecs[i].res, vecs[i].rw,
                  vecs[i].wr, vecs[i].v, vecs[i].rs, vecs[i].rt);
            tick();
            chk_port($sformatf("vec%0d", i), vecs[i].e_wdata, vecs[i].e_wreg, vecs[i].e_rw,
                     vecs[i].e_fa, vecs[i].e_fb, vecs[i].e_fda, vecs[i].e_fdb);
        end

        // ---------------- stall holds both entries ----------------
        drive(1'b1, 32'hD4, 32'h0, 1'b1, 5'd4, 1'b1, 5'd9, 5'd4);
        tick();   // WB=(1,r4,D4) RET=(1,r9,C1)
        chk_port("prestall", 32'hD4, 5'd4, 1'b1, 2'b10, 2'b01, 32'hC1, 32'hD4);
        cnt_before = RetireCount;
        Stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'h0, 32'hEE + c, 1'b1, 5'd6, 1'b1, 5'd9, 5'd4);
            tick();
            chk_port($sformatf("stall%0d", c), 32'hD4, 5'd4, 1'b1, 2'b10, 2'b01, 32'hC1, 32'hD4);
            chk($sformatf("stall%0d.RetireCount", c), RetireCount, cnt_before);
        end
        Stall = 1'b0;
        drive(1'b0, 32'h0, 32'hEE, 1'b1, 5'd6, 1'b1, 5'd9, 5'd4);
        tick();   // WB=(1,r6,EE) RET=(1,r4,D4)
        chk_port("unstall", 32'hEE, 5'd6, 1'b1, 2'b00, 2'b10, 32'h0, 32'hD4);

        // ---------------- stall + flush ----------------
        Stall = 1'b1; Flush = 1'b1;
        drive(1'b0, 32'h0, 32'h70, 1'b1, 5'd7, 1'b1, 5'd6, 5'd4);
        tick();   // WB killed, RET held (1,r4,D4)
        chk("stflush.RegWrite", {31'd0, RegWrite}, 32'h0);
        chk("stflush.ForwardA", {30'd0, ForwardA}, 32'h0);
        chk("stflush.FwdDataA", FwdDataA, 32'h0);
        chk("stflush.ForwardB", {30'd0, ForwardB}, 32'h2);
        chk("stflush.FwdDataB", FwdDataB, 32'hD4);

        // ---------------- flush without stall ----------------
        Stall = 1'b0; Flush = 1'b1;
        drive(1'b0, 32'h0, 32'h22, 1'b1, 5'd2, 1'b1, 5'd2, 5'd4);
        tick();   // WB invalid, RET <= killed entry (invalid)
        chk("flush.RegWrite", {31'd0, RegWrite}, 32'h0);
        chk("flush.ForwardA", {30'd0, ForwardA}, 32'h0);
        chk("flush.ForwardB", {30'd0, ForwardB}, 32'h0);
        Flush = 1'b0;

        // ---------------- reset wins over stall and flush ----------------
        drive(1'b0, 32'h0, 32'h55, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
        tick();
        chk("prereset.RegWrite", {31'd0, RegWrite}, 32'h1);
        Rst = 1'b0; Stall = 1'b1; Flush = 1'b1;
        tick();
        chk_port("rststall", 32'h0, 5'd0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk("rststall.RetireCount", RetireCount, 32'h0);
        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;

`ifdef MEM_WB_RETIRE_COUNT_EN
        // ---------------- counter: count then wrap ----------------
        drive(1'b0, 32'h0, 32'h1, 1'b0, 5'd1, 1'b1, 5'd0, 5'd0);
        tick();   // WB retire bit set; counter still 0
        chk("cnt.first", RetireCount, 32'h0);
        tick();   // one retirement counted, new valid captured again
        chk("cnt.one", RetireCount, 32'h1);
        force dut.retire_cnt = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt;
        Valid_in = 1'b0;
        tick();
        chk("cnt.wrap", RetireCount, 32'h0);
`else
        // ---------------- counter disabled ----------------
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'h0, 32'h1, 1'b0, 5'd1, 1'b1, 5'd0, 5'd0);
            tick();
            chk($sformatf("nocnt%0d", c), RetireCount, 32'h0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
